e203_csr_regs: RTL
==================

# e203_csr_regs

Machine-mode CSR register bank for the E203 EXU, directly downstream of the ALU CSR-control stage. It consumes that stage's enable, read/write strobes, CSR index and write-back data, and returns combinational read data plus an access-illegal flag in the same cycle. It also holds trap-state updates from the commit unit and the 64-bit cycle/instret counters.

## Interface
- HART_ID, 0: value returned by mhartid.
- MTVEC_RST, 32'h0000_0000: reset value of mtvec; bits [1:0] are ignored.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- csr_ena  in  1  CSR access this cycle, already qualified by valid & ready
- csr_wr_en  in  1  write strobe, meaningful only with csr_ena
- csr_rd_en  in  1  read strobe, meaningful only with csr_ena
- csr_idx  in  12  CSR address
- wbck_csr_dat  in  32  final write value, with RW/RS/RC merging already done upstream
- read_csr_dat  out  32  combinational read data
- csr_access_ilgl  out  1  combinational illegal-access flag
- cmt_trap_ena  in  1  trap entry pulse
- cmt_epc  in  32  trap PC
- cmt_cause  in  32  trap cause
- cmt_tval  in  32  trap value
- cmt_mret_ena  in  1  mret commit pulse
- cmt_instret_ena  in  1  one instruction retired
- status_mie_r  out  1  mstatus.MIE
- mie_r  out  32  mie register
- mtvec_r  out  32  mtvec register
- mepc_r  out  32  mepc register

## Operation
- Registers and writable fields:
  - mstatus 0x300: MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: reads 32'h4000_1104; writes are ignored and are not illegal.
  - mie 0x304: bits 3, 7 and 11 are writable.
  - mtvec 0x305: [31:2] writable; [1:0] read 0.
  - mscratch 0x340: 32 bits, all writable.
  - mepc 0x341: [31:1] writable; bit 0 reads 0.
  - mcause 0x342 and mtval 0x343: 32 bits, all writable.
  - mvendorid, marchid, mimpid (0xF11–0xF13): read 0.
  - mhartid 0xF14: reads HART_ID.
- csr_access_ilgl is asserted when:
  - csr_ena is high and the index is not implemented, or
  - csr_ena & csr_wr_en are high and csr_idx[11:10]==2'b11 (read-only space).
- An illegal access changes no state. read_csr_dat is 0 when the access is illegal or csr_rd_en is low.
- Write occurs when csr_ena & csr_wr_en & !csr_access_ilgl.
- Trap entry (cmt_trap_ena): mepc←{cmt_epc[31:1],0}, mcause←cmt_cause, mtval←cmt_tval, MPIE←MIE, MIE←0.
- mret (cmt_mret_ena): MIE←MPIE, MPIE←1.
- Same-cycle priority: cmt_trap_ena > cmt_mret_ena > CSR write, applied per register. Non-conflicting registers still take the CSR write.
- Reset: all registers are 0 except mtvec = {MTVEC_RST[31:2],2'b00}.
- Output reset values:
  - status_mie_r = 0, mie_r = 0, mepc_r = 0, mtvec_r = MTVEC_RST & ~3.
  - read_csr_dat and csr_access_ilgl follow their inputs combinationally.

## Timing
- Reads are zero-latency: data is valid in the same cycle as csr_ena and reflects the pre-write value.
- Writes are visible from the next cycle.
- Register outputs (status_mie_r, mie_r, mtvec_r, mepc_r) are flop outputs with no combinational input path.
- Counters are 64 bits and wrap from all-ones to 0 with no flag.
- Counter write in the same cycle as an increment:
  - Writing the low half: low←data; no carry is generated that cycle.
  - Writing the high half: high←data; low increments normally and any carry out of low is dropped.
- rst asserted mid-trap or mid-write: reset wins on the next edge.

## Configuration
- E203_CSR_CNT_EN defined:
  - Implements mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82 and mcountinhibit 0x320.
  - mcountinhibit: CY=bit0, IR=bit2 writable; all other bits read 0.
  - mcycle increments every cycle unless CY is set.
  - minstret increments on cmt_instret_ena unless IR is set.
- Undefined: these indices are unimplemented (illegal), no counter flops exist, and cmt_instret_ena is ignored.

## Structure
- Package e203_csr_pkg holds:
  - CSR index localparams;
  - MISA_VAL;
  - mstatus bit positions (MIE=3, MPIE=7);
  - mcountinhibit bit positions.
- Sub-module e203_csr_cnt64: a 64-bit counter with inc, low-write, high-write, 32-bit write data and synchronous reset. It is instantiated twice under E203_CSR_CNT_EN.

## Test plan
- Reset with MTVEC_RST=32'h8000_0003 → read mtvec returns 32'h8000_0000; mstatus returns 32'h0000_1800; mhartid returns HART_ID.
- Write mscratch 32'hDEAD_BEEF, then read on the next cycle → 32'hDEAD_BEEF; read in the same cycle as the write → old value 0.
- csr_ena & csr_wr_en to 0xF14 → csr_access_ilgl=1 and no state change. csr_ena to 0x7C0 → csr_access_ilgl=1 and read_csr_dat=0.
- MIE=1, cmt_trap_ena with cmt_epc=32'h0000_1235 and a simultaneous CSR write of mepc=32'h44 → mepc=32'h1234, MPIE=1, MIE=0. Then cmt_mret_ena → MIE=1, MPIE=1.
- Macro on: write mcycle=32'hFFFF_FFFE, mcycleh=0 → after 2 cycles mcycleh=1 and mcycle=0. Set mcountinhibit=1 → mcycle holds. Pulse cmt_instret_ena 3 times → minstret=3.
- Macro off: read 0xB00 → csr_access_ilgl=1 and read_csr_dat=0.

Source files
------------

// File: rtl/e203_csr_pkg.sv
// rtl/e203_csr_pkg.sv - CSR indices, constant read values and field positions for the E203 M-mode CSR bank
package e203_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MISA_VAL    = 32'h4000_1104;
  localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int CNTINH_CY    = 0;
  localparam int CNTINH_IR    = 2;

  // Indices with [11:10]==2'b11 are architecturally read-only.
  function automatic logic is_ro_space(input logic [11:0] idx);
    return idx[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/e203_csr_cnt64.sv
// rtl/e203_csr_cnt64.sv - 64-bit CSR counter with independent low/high half writes
module e203_csr_cnt64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 64'd0;
    end else if (wr_lo) begin
      // Low-half write suppresses the increment, so nothing carries into high.
      cnt[31:0] <= wdata;
    end else if (wr_hi) begin
      // Low keeps counting; its carry-out is lost under the high-half write.
      cnt[63:32] <= wdata;
      cnt[31:0]  <= cnt[31:0] + {31'd0, inc};
    end else if (inc) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/e203_csr_regs.sv
// rtl/e203_csr_regs.sv - E203 machine-mode CSR bank; counters built only with E203_CSR_CNT_EN
module e203_csr_regs
  import e203_csr_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_ena,
  input  logic        csr_wr_en,
  input  logic        csr_rd_en,
  input  logic [11:0] csr_idx,
  input  logic [31:0] wbck_csr_dat,
  output logic [31:0] read_csr_dat,
  output logic        csr_access_ilgl,
  input  logic        cmt_trap_ena,
  input  logic [31:0] cmt_epc,
  input  logic [31:0] cmt_cause,
  input  logic [31:0] cmt_tval,
  input  logic        cmt_mret_ena,
  input  logic        cmt_instret_ena,
  output logic        status_mie_r,
  output logic [31:0] mie_r,
  output logic [31:0] mtvec_r,
  output logic [31:0] mepc_r
);

  logic        mstatus_mpie;
  logic [31:0] mscratch_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [31:0] mstatus_val;
  logic [31:0] rd_raw;
  logic        csr_impl;
  logic        csr_wr;

  logic unused_epc0;
  assign unused_epc0 = cmt_epc[0];

  assign csr_access_ilgl = csr_ena & (~csr_impl | (csr_wr_en & is_ro_space(csr_idx)));
  assign csr_wr          = csr_ena & csr_wr_en & ~csr_access_ilgl;

  always_comb begin
    mstatus_val               = MSTATUS_MPP;
    mstatus_val[MSTATUS_MIE]  = status_mie_r;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
  end

`ifdef E203_CSR_CNT_EN
  logic        inhibit_cy;
  logic        inhibit_ir;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] mcountinhibit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_cy <= 1'b0;
      inhibit_ir <= 1'b0;
    end else if (csr_wr && (csr_idx == CSR_MCOUNTINHIBIT)) begin
      inhibit_cy <= wbck_csr_dat[CNTINH_CY];
      inhibit_ir <= wbck_csr_dat[CNTINH_IR];
    end
  end

  always_comb begin
    mcountinhibit_val            = 32'd0;
    mcountinhibit_val[CNTINH_CY] = inhibit_cy;
    mcountinhibit_val[CNTINH_IR] = inhibit_ir;
  end

  e203_csr_cnt64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (~inhibit_cy),
    .wr_lo (csr_wr & (csr_idx == CSR_MCYCLE)),
    .wr_hi (csr_wr & (csr_idx == CSR_MCYCLEH)),
    .wdata (wbck_csr_dat),
    .cnt   (mcycle)
  );

  e203_csr_cnt64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (cmt_instret_ena & ~inhibit_ir),
    .wr_lo (csr_wr & (csr_idx == CSR_MINSTRET)),
    .wr_hi (csr_wr & (csr_idx == CSR_MINSTRETH)),
    .wdata (wbck_csr_dat),
    .cnt   (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = cmt_instret_ena;
`endif

  always_comb begin
    csr_impl = 1'b1;
    rd_raw   = 32'd0;
    case (csr_idx)
      CSR_MSTATUS:   rd_raw = mstatus_val;
      CSR_MISA:      rd_raw = MISA_VAL;
      CSR_MIE:       rd_raw = mie_r;
      CSR_MTVEC:     rd_raw = mtvec_r;
      CSR_MSCRATCH:  rd_raw = mscratch_r;
      CSR_MEPC:      rd_raw = mepc_r;
      CSR_MCAUSE:    rd_raw = mcause_r;
      CSR_MTVAL:     rd_raw = mtval_r;
      CSR_MVENDORID: rd_raw = 32'd0;
      CSR_MARCHID:   rd_raw = 32'd0;
      CSR_MIMPID:    rd_raw = 32'd0;
      CSR_MHARTID:   rd_raw = HART_ID;
`ifdef E203_CSR_CNT_EN
      CSR_MCOUNTINHIBIT: rd_raw = mcountinhibit_val;
      CSR_MCYCLE:        rd_raw = mcycle[31:0];
      CSR_MCYCLEH:       rd_raw = mcycle[63:32];
      CSR_MINSTRET:      rd_raw = minstret[31:0];
      CSR_MINSTRETH:     rd_raw = minstret[63:32];
`endif
      default:       csr_impl = 1'b0;
    endcase
  end

  assign read_csr_dat = (csr_ena & csr_rd_en & ~csr_access_ilgl) ? rd_raw : 32'd0;

  // Commit-side events outrank the CSR write only on the registers they touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_mie_r <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r        <= 32'd0;
      mtvec_r      <= {MTVEC_RST[31:2], 2'b00};
      mscratch_r   <= 32'd0;
      mepc_r       <= 32'd0;
      mcause_r     <= 32'd0;
      mtval_r      <= 32'd0;
    end else begin
      if (cmt_trap_ena) begin
        status_mie_r <= 1'b0;
        mstatus_mpie <= status_mie_r;
      end else if (cmt_mret_ena) begin
        status_mie_r <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wr && (csr_idx == CSR_MSTATUS)) begin
        status_mie_r <= wbck_csr_dat[MSTATUS_MIE];
        mstatus_mpie <= wbck_csr_dat[MSTATUS_MPIE];
      end

      if (cmt_trap_ena) begin
        mepc_r   <= {cmt_epc[31:1], 1'b0};
        mcause_r <= cmt_cause;
        mtval_r  <= cmt_tval;
      end else if (csr_wr) begin
        if (csr_idx == CSR_MEPC)   mepc_r   <= {wbck_csr_dat[31:1], 1'b0};
        if (csr_idx == CSR_MCAUSE) mcause_r <= wbck_csr_dat;
        if (csr_idx == CSR_MTVAL)  mtval_r  <= wbck_csr_dat;
      end

      if (csr_wr) begin
        if (csr_idx == CSR_MIE)      mie_r      <= wbck_csr_dat & MIE_MASK;
        if (csr_idx == CSR_MTVEC)    mtvec_r    <= {wbck_csr_dat[31:2], 2'b00};
        if (csr_idx == CSR_MSCRATCH) mscratch_r <= wbck_csr_dat;
      end
    end
  end

endmodule
